button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
Multi-channel front end for the board's pushbuttons. It replaces separate per-button debounce and pulser instances with one parametrised block. Each channel has a 2-flop synchroniser, a debounce filter, registered rise and fall pulses, and an optional hold-to-repeat press stream. It sits between the raw btn*/jb pins and the consumers (user_io, game_fsm) in the 65 MHz clock domain.

Parameters:
N_CH, 4, number of independent input channels (>=1)
DB_COUNT, 1_000_000, consecutive stable cycles required to accept a new level (>=1)
HOLD_CYCLES, 32_500_000, cycles from the rise pulse to the first auto-repeat (>=1)
REPEAT_CYCLES, 6_500_000, cycles between later auto-repeats (>=1)
REPEAT_EN, N_CH'b0, per-channel bit mask; 1 enables auto-repeat on that channel

Ports:
clk_in  input  1  system clock (65 MHz)
rst_in_n  input  1  reset, asynchronous, active-low
noisy_in  input  N_CH  raw active-high button levels, asynchronous to clk_in
clean_out  output  N_CH  debounced level
rise_out  output  N_CH  1-cycle pulse on each accepted 0->1 transition
fall_out  output  N_CH  1-cycle pulse on each accepted 1->0 transition
press_out  output  N_CH  rise_out OR auto-repeat pulse (only 1-cycle pulses)
long_out  output  N_CH  high while the channel is in REPEATING

Behaviour:
- Reset: rst_in_n low asynchronously clears the synchronisers, counters, clean_out, rise_out, fall_out, press_out and long_out to 0, and puts every channel FSM in IDLE. This applies mid-debounce and mid-repeat. After release, no pulse is generated for a button that is already high until it passes the debounce filter.
- Channels are fully independent. Simultaneous events on any set of channels are all serviced in the same cycle.
- Synchroniser: sync1 <= noisy_in; sync2 <= sync1.
- Debounce, per channel (counter width $clog2(DB_COUNT)):
  - sync2 == clean: count <= 0.
  - sync2 != clean and count < DB_COUNT-1: count <= count+1.
  - sync2 != clean and count == DB_COUNT-1: clean <= sync2; count <= 0.
  - Net effect: a level must persist DB_COUNT consecutive cycles at sync2. A glitch of DB_COUNT-1 cycles is fully rejected.
  - Latency: if the new level is first sampled by sync1 at edge E, clean_out changes at edge E+DB_COUNT+1.
- Edge pulses (registered): rise_out is high for exactly the one cycle after clean_out goes 0->1. fall_out is the same for 1->0. Both are otherwise 0.
- Repeat FSM, per channel, with a hold counter of width $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)):
  - IDLE: on the rise event (same edge that asserts rise_out), go to HELD and set hcount <= 1.
  - HELD: if clean is 0, go to IDLE. Else, if REPEAT_EN[ch] and hcount == HOLD_CYCLES, fire a repeat pulse, go to REPEATING and set hcount <= 1. Else hcount <= hcount+1, saturating when REPEAT_EN[ch]=0.
  - REPEATING: if clean is 0, go to IDLE with no repeat pulse. Else, if hcount == REPEAT_CYCLES, fire a repeat pulse and set hcount <= 1. Else hcount <= hcount+1.
- Repeat timing: with rise_out high in cycle t, repeats appear in cycles t+HOLD_CYCLES, then t+HOLD_CYCLES+k*REPEAT_CYCLES.
- press_out = rise_out | repeat pulse. It is registered, so it is never wider than 1 cycle.
- long_out is high exactly while the channel is in REPEATING. It stays 0 on channels where REPEAT_EN=0.
- Release during HELD or REPEATING: fall_out pulses normally, the FSM returns to IDLE, and any partial repeat count is discarded. The next press restarts from HOLD_CYCLES.
- Counters never wrap: debounce is bounded by DB_COUNT-1, and hcount is reset or saturated as above.

Test Plan:
All scenarios use N_CH=3, DB_COUNT=4, HOLD_CYCLES=10, REPEAT_CYCLES=5, REPEAT_EN=3'b010.
1. Basic press: ch0 driven 0->1 and held, first sampled at edge E -> clean_out[0] rises at E+5; rise_out[0] and press_out[0] each pulse once, for one cycle. Release -> fall_out[0] pulses once, 5 edges after the release is sampled.
2. Glitch: ch0 high for 3 cycles, then low -> clean_out, rise_out and press_out stay 0. The same input held for 4 cycles -> accepted.
3. Auto-repeat: ch1 held 40 cycles after rise_out at cycle t -> press_out[1] pulses at t, t+10, t+15, t+20, t+25, t+30, t+35 (until release). long_out[1] is high from t+10 until release.
4. Repeat disabled: ch2 held 40 cycles -> exactly one press_out[2] pulse, and long_out[2] stays 0.
5. Release mid-repeat plus concurrency: ch1 released at t+17 while ch0 and ch2 are pressed in the same cycle -> no further ch1 repeats, long_out[1] drops, and ch0/ch2 rise pulses occur in the same cycle as each other.
6. Async reset: rst_in_n pulled low mid-REPEATING on ch1, between clock edges -> all outputs read 0 immediately. After release with the button still held -> rise_out[1] appears again DB_COUNT+1 edges after the first sampling edge, and a repeat follows 10 cycles after it.

Source files
------------

// File: rtl/button_conditioner.sv
// Multi-channel pushbutton front end: 2-flop synchroniser, debounce filter,
// registered rise/fall pulses and optional hold-to-repeat press stream per channel.
module button_conditioner #(
  parameter int              N_CH          = 4,
  parameter int              DB_COUNT      = 1_000_000,
  parameter int              HOLD_CYCLES   = 32_500_000,
  parameter int              REPEAT_CYCLES = 6_500_000,
  parameter logic [N_CH-1:0] REPEAT_EN     = '0
) (
  input  logic            clk_in,
  input  logic            rst_in_n,
  input  logic [N_CH-1:0] noisy_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_out,
  output logic [N_CH-1:0] fall_out,
  output logic [N_CH-1:0] press_out,
  output logic [N_CH-1:0] long_out
);

  localparam int DB_W  = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam int H_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  // One extra value so the counter can hold H_MAX even when it is a power of two
  localparam int H_W   = $clog2(H_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HELD      = 2'd1,
    ST_REPEATING = 2'd2
  } state_e;

  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= noisy_in;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [DB_W-1:0] r_db_cnt;
    logic            r_clean;
    logic            r_rise;
    logic            r_fall;
    logic            r_press;
    logic            r_long;
    logic [H_W-1:0]  r_hcount;
    logic [H_W-1:0]  w_hcount_nxt;
    state_e          r_state;
    state_e          w_state_nxt;
    logic            w_accept;
    logic            w_rise_ev;
    logic            w_fall_ev;
    logic            w_rep_fire;

    assign w_accept  = (r_sync2[g] != r_clean) && (r_db_cnt == DB_W'(DB_COUNT - 1));
    assign w_rise_ev = w_accept && r_sync2[g];
    assign w_fall_ev = w_accept && !r_sync2[g];

    always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
        r_db_cnt <= '0;
        r_clean  <= 1'b0;
      end else if (r_sync2[g] == r_clean) begin
        r_db_cnt <= '0;
      end else if (w_accept) begin
        r_db_cnt <= '0;
        r_clean  <= r_sync2[g];
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end

    // A new rise always restarts the hold interval, whatever state we were in
    always_comb begin
      w_state_nxt  = r_state;
      w_hcount_nxt = r_hcount;
      w_rep_fire   = 1'b0;
      if (w_rise_ev) begin
        w_state_nxt  = ST_HELD;
        w_hcount_nxt = H_W'(1);
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_state_nxt  = ST_IDLE;
            w_hcount_nxt = r_hcount;
          end
          ST_HELD: begin
            if (!r_clean) begin
              w_state_nxt  = ST_IDLE;
              w_hcount_nxt = '0;
            end else if (REPEAT_EN[g] && (r_hcount == H_W'(HOLD_CYCLES))) begin
              w_rep_fire   = 1'b1;
              w_state_nxt  = ST_REPEATING;
              w_hcount_nxt = H_W'(1);
            end else if (REPEAT_EN[g] || (r_hcount != '1)) begin
              w_hcount_nxt = r_hcount + H_W'(1);
            end else begin
              w_hcount_nxt = r_hcount;
            end
          end
          ST_REPEATING: begin
            if (!r_clean) begin
              w_state_nxt  = ST_IDLE;
              w_hcount_nxt = '0;
            end else if (r_hcount == H_W'(REPEAT_CYCLES)) begin
              w_rep_fire   = 1'b1;
              w_hcount_nxt = H_W'(1);
            end else begin
              w_hcount_nxt = r_hcount + H_W'(1);
            end
          end
          default: begin
            w_state_nxt  = ST_IDLE;
            w_hcount_nxt = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
        r_state  <= ST_IDLE;
        r_hcount <= '0;
        r_rise   <= 1'b0;
        r_fall   <= 1'b0;
        r_press  <= 1'b0;
        r_long   <= 1'b0;
      end else begin
        r_state  <= w_state_nxt;
        r_hcount <= w_hcount_nxt;
        r_rise   <= w_rise_ev;
        r_fall   <= w_fall_ev;
        r_press  <= w_rise_ev | w_rep_fire;
        r_long   <= (w_state_nxt == ST_REPEATING);
      end
    end

    assign clean_out[g] = r_clean;
    assign rise_out[g]  = r_rise;
    assign fall_out[g]  = r_fall;
    assign press_out[g] = r_press;
    assign long_out[g]  = r_long;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised bench for button_conditioner: random press/glitch patterns and async
// resets, checked each cycle against a history/timestamp reference model.
module tb_button_conditioner;

  localparam int              N_CH = 3;
  localparam int              DB   = 4;
  localparam int              HOLD = 10;
  localparam int              REP  = 5;
  localparam logic [N_CH-1:0] REN  = 3'b010;

  logic            clk_in;
  logic            rst_in_n;
  logic [N_CH-1:0] noisy_in;
  logic [N_CH-1:0] clean_out, rise_out, fall_out, press_out, long_out;

  button_conditioner #(
    .N_CH(N_CH), .DB_COUNT(DB), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .REPEAT_EN(REN)
  ) dut (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .noisy_in(noisy_in),
    .clean_out(clean_out), .rise_out(rise_out), .fall_out(fall_out),
    .press_out(press_out), .long_out(long_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_vec;
  int n_err;
  int cyc;

  // Reference model: sync pipeline, last-DB-samples history, and rise timestamp
  logic [N_CH-1:0] m_s1, m_s2, m_clean;
  logic [N_CH-1:0] e_rise, e_fall, e_press, e_long;
  logic [N_CH-1:0] ren_mask;
  logic [DB-1:0]   m_hist [N_CH];
  int              m_trise [N_CH];

  task automatic chk(input string tag, input logic [N_CH-1:0] obs, input logic [N_CH-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_clean = '0;
    e_rise = '0; e_fall = '0; e_press = '0; e_long = '0;
    for (int c = 0; c < N_CH; c++) begin
      m_hist[c]  = '0;
      m_trise[c] = -1;
    end
  endtask

  task automatic model_edge(input logic [N_CH-1:0] pins);
    logic [N_CH-1:0] old_s2, old_clean;
    old_s2    = m_s2;
    old_clean = m_clean;
    m_s2      = m_s1;
    m_s1      = pins;
    e_rise = '0; e_fall = '0; e_press = '0; e_long = '0;
    for (int c = 0; c < N_CH; c++) begin
      logic [DB-1:0] h;
      logic [DB-1:0] want;
      bit            accept;
      bit            fire;
      int            d;
      h          = {m_hist[c][DB-2:0], old_s2[c]};
      m_hist[c]  = h;
      want       = {DB{~old_clean[c]}};
      accept     = (h == want);
      if (accept) m_clean[c] = ~old_clean[c];
      e_rise[c]  = accept && !old_clean[c];
      e_fall[c]  = accept && old_clean[c];
      fire       = 1'b0;
      if (e_rise[c]) begin
        m_trise[c] = cyc;
      end else if (m_trise[c] >= 0) begin
        if (!old_clean[c]) begin
          m_trise[c] = -1;
        end else if (ren_mask[c]) begin
          d    = cyc - m_trise[c];
          fire = (d == HOLD) || (d > HOLD && ((d - HOLD) % REP) == 0);
        end
      end
      e_press[c] = e_rise[c] | fire;
      e_long[c]  = ren_mask[c] && (m_trise[c] >= 0) && ((cyc - m_trise[c]) >= HOLD);
    end
  endtask

  task automatic check_all(input string phase);
    chk({phase, ".clean"}, clean_out, m_clean);
    chk({phase, ".rise"},  rise_out,  e_rise);
    chk({phase, ".fall"},  fall_out,  e_fall);
    chk({phase, ".press"}, press_out, e_press);
    chk({phase, ".long"},  long_out,  e_long);
  endtask

  logic [N_CH-1:0] pins;
  int              rem [N_CH];
  bit              hold_rst;

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    ren_mask = REN;
    hold_rst = 1'b0;
    pins     = '0;
    noisy_in = '0;
    rst_in_n = 1'b0;
    model_reset();
    for (int c = 0; c < N_CH; c++) rem[c] = $urandom_range(2, 20);
    repeat (3) @(posedge clk_in);
    #1 check_all("reset");

    for (int k = 0; k < 4000; k++) begin
      @(negedge clk_in);
      if (k == 0 || hold_rst) begin
        rst_in_n = 1'b1;
        hold_rst = 1'b0;
      end
      for (int c = 0; c < N_CH; c++) begin
        if (rem[c] == 0) begin
          pins[c] = ~pins[c];
          rem[c]  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6))
                                                : int'($urandom_range(8, 70));
        end else begin
          rem[c]--;
        end
      end
      // Occasionally press every channel together to exercise same-cycle events
      if ($urandom_range(0, 149) == 0) begin
        pins = '1;
        for (int c = 0; c < N_CH; c++) rem[c] = 45;
      end
      noisy_in = pins;
      if (k > 20 && $urandom_range(0, 399) == 0) begin
        #2 rst_in_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        hold_rst = 1'b1;
      end
      @(posedge clk_in);
      cyc++;
      if (!rst_in_n) model_reset();
      else model_edge(noisy_in);
      #1 check_all("run");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
